// File: rtl/hub75_scanner.sv
// HUB75 1/16-scan panel scanner: fetches RGB565 pixels from the frame
// buffer, shifts one bit-plane per pass and applies BCM brightness.
module hub75_scanner #(
  parameter int BRIGHTNESS_BASE       = 8,
  parameter int DISPLAY_COUNTER_WIDTH = 12
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [2:0]  rgb_enable,
  input  logic [5:0]  brightness_enable,
  output logic [11:0] ram_address,
  output logic        ram_read_enable,
  input  logic [7:0]  ram_data_in,
  output logic [2:0]  hub75_rgb1,
  output logic [2:0]  hub75_rgb2,
  output logic        hub75_clk,
  output logic        hub75_latch,
  output logic        hub75_oe_n,
  output logic [3:0]  hub75_row_addr,
  output logic        frame_start
);

  localparam int CW = DISPLAY_COUNTER_WIDTH;

  typedef enum logic [1:0] {
    S_FETCH,
    S_LATCH,
    S_DISPLAY
  } state_e;

  // Sequencer state describes the cycle issued at the next edge;
  // every output is registered from it.
  state_e         state_q, state_d;
  logic [2:0]     sub_q, sub_d;
  logic [5:0]     col_q, col_d;
  logic [3:0]     row_q, row_d;
  logic [2:0]     plane_q, plane_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           oe_en_q, oe_en_d;

  logic [7:0]     top_hi_q, top_hi_d;
  logic [7:0]     top_lo_q, top_lo_d;
  logic [7:0]     bot_hi_q, bot_hi_d;

  logic [11:0]    addr_q, addr_d;
  logic           ren_q, ren_d;
  logic [2:0]     rgb1_q, rgb1_d;
  logic [2:0]     rgb2_q, rgb2_d;
  logic           hclk_q, hclk_d;
  logic           latch_q, latch_d;
  logic           oe_n_q, oe_n_d;
  logic [3:0]     row_addr_q, row_addr_d;
  logic           fstart_q, fstart_d;

  logic [CW-1:0]  disp_len;
  logic [CW-1:0]  disp_last;
  logic           disp_en;

  assign disp_len  = CW'(BRIGHTNESS_BASE) << plane_q;
  assign disp_last = disp_len - CW'(1);

  // RGB565 -> one bit of each 6-bit channel, colour-gated.
  function automatic logic [2:0] decode(
    input logic [7:0] hi,
    input logic [7:0] lo,
    input logic [2:0] p,
    input logic [2:0] en
  );
    logic [5:0] r6;
    logic [5:0] g6;
    logic [5:0] b6;
    r6 = {hi[7:3], hi[7]};
    g6 = {hi[2:0], lo[7:5]};
    b6 = {lo[4:0], lo[4]};
    return {b6[p] & en[2], g6[p] & en[1], r6[p] & en[0]};
  endfunction

  // Next sequencer state, pixel capture and registered output values.
  always_comb begin
    state_d    = state_q;
    sub_d      = sub_q;
    col_d      = col_q;
    row_d      = row_q;
    plane_d    = plane_q;
    cnt_d      = cnt_q;
    oe_en_d    = oe_en_q;
    top_hi_d   = top_hi_q;
    top_lo_d   = top_lo_q;
    bot_hi_d   = bot_hi_q;
    addr_d     = addr_q;
    ren_d      = 1'b0;
    rgb1_d     = rgb1_q;
    rgb2_d     = rgb2_q;
    hclk_d     = 1'b0;
    latch_d    = 1'b0;
    oe_n_d     = 1'b1;
    row_addr_d = row_addr_q;
    fstart_d   = 1'b0;
    disp_en    = oe_en_q;

    unique case (state_q)
      S_FETCH: begin
        unique case (sub_q)
          3'd0: begin
            addr_d   = {1'b0, row_q, col_q, 1'b1};
            ren_d    = 1'b1;
            fstart_d = (row_q == 4'd0) && (col_q == 6'd0) &&
                       (plane_q == 3'd5);
          end
          3'd1: begin
            addr_d = {1'b0, row_q, col_q, 1'b0};
            ren_d  = 1'b1;
          end
          3'd2: begin
            addr_d   = {1'b1, row_q, col_q, 1'b1};
            ren_d    = 1'b1;
            top_hi_d = ram_data_in;
          end
          3'd3: begin
            addr_d   = {1'b1, row_q, col_q, 1'b0};
            ren_d    = 1'b1;
            top_lo_d = ram_data_in;
          end
          3'd4: begin
            bot_hi_d = ram_data_in;
          end
          default: begin
            hclk_d = 1'b1;
            rgb1_d = decode(top_hi_q, top_lo_q, plane_q, rgb_enable);
            rgb2_d = decode(bot_hi_q, ram_data_in, plane_q, rgb_enable);
          end
        endcase
        if (sub_q == 3'd5) begin
          sub_d = 3'd0;
          if (col_q == 6'd63) begin
            col_d   = 6'd0;
            state_d = S_LATCH;
          end else begin
            col_d = col_q + 6'd1;
          end
        end else begin
          sub_d = sub_q + 3'd1;
        end
      end
      S_LATCH: begin
        latch_d    = 1'b1;
        row_addr_d = row_q;
        cnt_d      = '0;
        state_d    = S_DISPLAY;
      end
      S_DISPLAY: begin
        if (cnt_q == '0) disp_en = brightness_enable[plane_q];
        oe_en_d = disp_en;
        oe_n_d  = ~disp_en;
        if (cnt_q == disp_last) begin
          cnt_d   = '0;
          state_d = S_FETCH;
          if (plane_q == 3'd0) begin
            plane_d = 3'd5;
            row_d   = row_q + 4'd1;
          end else begin
            plane_d = plane_q - 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q    <= S_FETCH;
      sub_q      <= 3'd0;
      col_q      <= 6'd0;
      row_q      <= 4'd0;
      plane_q    <= 3'd5;
      cnt_q      <= '0;
      oe_en_q    <= 1'b0;
      top_hi_q   <= 8'd0;
      top_lo_q   <= 8'd0;
      bot_hi_q   <= 8'd0;
      addr_q     <= 12'd0;
      ren_q      <= 1'b0;
      rgb1_q     <= 3'd0;
      rgb2_q     <= 3'd0;
      hclk_q     <= 1'b0;
      latch_q    <= 1'b0;
      oe_n_q     <= 1'b1;
      row_addr_q <= 4'd0;
      fstart_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sub_q      <= sub_d;
      col_q      <= col_d;
      row_q      <= row_d;
      plane_q    <= plane_d;
      cnt_q      <= cnt_d;
      oe_en_q    <= oe_en_d;
      top_hi_q   <= top_hi_d;
      top_lo_q   <= top_lo_d;
      bot_hi_q   <= bot_hi_d;
      addr_q     <= addr_d;
      ren_q      <= ren_d;
      rgb1_q     <= rgb1_d;
      rgb2_q     <= rgb2_d;
      hclk_q     <= hclk_d;
      latch_q    <= latch_d;
      oe_n_q     <= oe_n_d;
      row_addr_q <= row_addr_d;
      fstart_q   <= fstart_d;
    end
  end

  assign ram_address     = addr_q;
  assign ram_read_enable = ren_q;
  assign hub75_rgb1      = rgb1_q;
  assign hub75_rgb2      = rgb2_q;
  assign hub75_clk       = hclk_q;
  assign hub75_latch     = latch_q;
  assign hub75_oe_n      = oe_n_q;
  assign hub75_row_addr  = row_addr_q;
  assign frame_start     = fstart_q;

endmodule

// File: tb/tb_hub75_scanner.sv
// Bench for hub75_scanner: cycle-exact reference built from the frame
// timing arithmetic, random frame-buffer contents and enables.
module tb_hub75_scanner;

  localparam int BASE = 8;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  rgb_enable = 3'b111;
  logic [5:0]  brightness_enable = 6'b111111;
  logic [11:0] ram_address;
  logic        ram_read_enable;
  logic [7:0]  ram_data_in = 8'd0;
  logic [2:0]  hub75_rgb1;
  logic [2:0]  hub75_rgb2;
  logic        hub75_clk;
  logic        hub75_latch;
  logic        hub75_oe_n;
  logic [3:0]  hub75_row_addr;
  logic        frame_start;

  int checks = 0;
  int failures = 0;
  int cur_t = 0;

  logic [7:0] mem [4096];

  typedef struct {
    int         addr;
    logic       ren;
    logic [2:0] rgb1;
    logic [2:0] rgb2;
    logic       hclk;
    logic       latch;
    logic       oe_n;
    int         raddr;
    logic       fs;
  } exp_t;

  hub75_scanner #(
    .BRIGHTNESS_BASE(BASE),
    .DISPLAY_COUNTER_WIDTH(12)
  ) dut (
    .clk_in(clk_in),
    .reset(reset),
    .rgb_enable(rgb_enable),
    .brightness_enable(brightness_enable),
    .ram_address(ram_address),
    .ram_read_enable(ram_read_enable),
    .ram_data_in(ram_data_in),
    .hub75_rgb1(hub75_rgb1),
    .hub75_rgb2(hub75_rgb2),
    .hub75_clk(hub75_clk),
    .hub75_latch(hub75_latch),
    .hub75_oe_n(hub75_oe_n),
    .hub75_row_addr(hub75_row_addr),
    .frame_start(frame_start)
  );

  always #5 clk_in = ~clk_in;

  // Synchronous-read frame buffer: data one cycle after the address.
  always @(posedge clk_in) ram_data_in <= mem[ram_address];

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, cur_t, obs, expv);
    end
  endtask

  function automatic logic [2:0] ref_pix(int row, int plane, int col, int half);
    int base, hi, lo, r, g, b, r6, b6;
    base = half * 2048 + row * 128 + col * 2;
    hi = int'(mem[base + 1]);
    lo = int'(mem[base]);
    r = hi / 8;
    g = (hi % 8) * 8 + lo / 32;
    b = lo % 32;
    r6 = r * 2 + r / 16;
    b6 = b * 2 + b / 16;
    ref_pix[0] = ((r6 >> plane) & 1) == 1 && rgb_enable[0];
    ref_pix[1] = ((g >> plane) & 1) == 1 && rgb_enable[1];
    ref_pix[2] = ((b6 >> plane) & 1) == 1 && rgb_enable[2];
  endfunction

  function automatic exp_t ref_model(int t);
    exp_t e;
    int rp, tf, row, tr, pos, plane, col, s, prow, ppl, pcol;
    bit have;
    rp = 0;
    for (int p = 0; p < 6; p++) rp += 385 + (BASE << p);
    tf = t % (16 * rp);
    row = tf / rp;
    tr = tf % rp;
    pos = tr;
    plane = 5;
    while (pos >= 385 + (BASE << plane)) begin
      pos -= 385 + (BASE << plane);
      plane--;
    end
    e.ren = 1'b0;
    e.hclk = 1'b0;
    e.latch = 1'b0;
    e.oe_n = 1'b1;
    e.fs = (tf == 0);
    have = 1'b1;
    prow = row;
    ppl = plane;
    pcol = 63;
    if (pos < 384) begin
      col = pos / 6;
      s = pos % 6;
      if (s < 4) begin
        e.ren = 1'b1;
        e.addr = (s / 2) * 2048 + row * 128 + col * 2 + ((s % 2 == 0) ? 1 : 0);
      end else begin
        e.addr = 2048 + row * 128 + col * 2;
      end
      e.hclk = (s == 5);
      if (s == 5) pcol = col;
      else if (col > 0) pcol = col - 1;
      else if (plane < 5) ppl = plane + 1;
      else if (t < 5) have = 1'b0;
      else begin
        prow = (row + 15) % 16;
        ppl = 0;
      end
    end else begin
      e.addr = 2048 + row * 128 + 126;
      if (pos == 384) e.latch = 1'b1;
      else e.oe_n = ~brightness_enable[plane];
    end
    if (have) begin
      e.rgb1 = ref_pix(prow, ppl, pcol, 0);
      e.rgb2 = ref_pix(prow, ppl, pcol, 1);
    end else begin
      e.rgb1 = 3'b000;
      e.rgb2 = 3'b000;
    end
    if (tr >= 384) e.raddr = row;
    else if (t < 384) e.raddr = 0;
    else e.raddr = (row + 15) % 16;
    return e;
  endfunction

  task automatic check_cycle(input int t);
    exp_t e;
    e = ref_model(t);
    cur_t = t;
    chk("ram_address", int'(ram_address), e.addr);
    chk("ram_read_enable", int'(ram_read_enable), int'(e.ren));
    chk("rgb1", int'(hub75_rgb1), int'(e.rgb1));
    chk("rgb2", int'(hub75_rgb2), int'(e.rgb2));
    chk("hub75_clk", int'(hub75_clk), int'(e.hclk));
    chk("latch", int'(hub75_latch), int'(e.latch));
    chk("oe_n", int'(hub75_oe_n), int'(e.oe_n));
    chk("row_addr", int'(hub75_row_addr), e.raddr);
    chk("frame_start", int'(frame_start), int'(e.fs));
  endtask

  task automatic check_reset_vals();
    cur_t = -1;
    chk("rst_addr", int'(ram_address), 0);
    chk("rst_ren", int'(ram_read_enable), 0);
    chk("rst_rgb1", int'(hub75_rgb1), 0);
    chk("rst_rgb2", int'(hub75_rgb2), 0);
    chk("rst_clk", int'(hub75_clk), 0);
    chk("rst_latch", int'(hub75_latch), 0);
    chk("rst_oe_n", int'(hub75_oe_n), 1);
    chk("rst_row_addr", int'(hub75_row_addr), 0);
    chk("rst_frame_start", int'(frame_start), 0);
  endtask

  task automatic hold_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
      check_reset_vals();
    end
  endtask

  task automatic run(input int t0, input int n);
    for (int t = t0; t < t0 + n; t++) begin
      @(posedge clk_in);
      #1;
      check_cycle(t);
    end
  endtask

  initial begin
    // Random picture, red top-left and blue bottom-left pixel, BCM mask.
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[1] = 8'hF8;
    mem[0] = 8'h00;
    mem[2049] = 8'h00;
    mem[2048] = 8'h1F;
    rgb_enable = 3'b111;
    brightness_enable = 6'b110111;
    hold_reset(3);
    reset = 1'b0;
    run(0, 6);
    cur_t = 5;
    chk("first_col_rgb1", int'(hub75_rgb1), 1);
    chk("first_col_rgb2", int'(hub75_rgb2), 4);
    run(6, 45100);

    // Random enables, then reset in the middle of column 30.
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    rgb_enable = 3'($urandom);
    brightness_enable = 6'($urandom);
    hold_reset(2);
    reset = 1'b0;
    run(0, 184);
    hold_reset(1);
    rgb_enable = 3'($urandom);
    brightness_enable = 6'($urandom);
    hold_reset(1);
    reset = 1'b0;
    run(0, 6000);

    // White frame with red disabled.
    for (int i = 0; i < 4096; i++) mem[i] = 8'hFF;
    rgb_enable = 3'b110;
    brightness_enable = 6'($urandom);
    hold_reset(2);
    reset = 1'b0;
    run(0, 6000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hub75_scanner.md
Name: hub75_scanner

Overview:
Downstream consumer of the UART command/frame-buffer writer. Reads the 32x64 RGB565 frame buffer through the RAM read port and shifts pixel bit-planes into a 1/16-scan HUB75 panel, row pair by row pair. Applies binary-coded-modulation brightness and the colour/bit-plane enables produced by the control stage. The frame buffer is addressed {row[4:0], col[5:0], byte_sel}; byte_sel=1 is the high byte RRRRRGGG and byte_sel=0 is the low byte GGGBBBBB.

Parameters:
BRIGHTNESS_BASE, 8, display cycles for bit-plane 0; plane p is displayed for BRIGHTNESS_BASE<<p cycles.
DISPLAY_COUNTER_WIDTH, 12, width of the display-time counter; must hold BRIGHTNESS_BASE<<5.

Ports:
clk_in  input  1  clock for all logic; rising edge.
reset  input  1  synchronous, active-high.
rgb_enable  input  3  per-colour enable; [0]=R, [1]=G, [2]=B.
brightness_enable  input  6  per-bit-plane enable; [p] gates plane p.
ram_address  output  12  frame-buffer read address.
ram_read_enable  output  1  high on cycles that present a valid read address.
ram_data_in  input  8  read data, valid exactly 1 cycle after its address.
hub75_rgb1  output  3  top-half data {B,G,R} for rows 0-15.
hub75_rgb2  output  3  bottom-half data {B,G,R} for rows 16-31.
hub75_clk  output  1  panel shift clock.
hub75_latch  output  1  panel latch.
hub75_oe_n  output  1  panel output enable, active low.
hub75_row_addr  output  4  displayed row pair.
frame_start  output  1  one-cycle pulse at the start of each frame.

Behaviour:
- One clock, clk_in. Reset is synchronous and active-high. All state and outputs update on posedge clk_in.
- Reset values: oe_n=1, clk=0, latch=0, rgb1=rgb2=0, row_addr=0, ram_address=0, ram_read_enable=0, frame_start=0. Internal state: row pair=0, plane=5, column=0, state=FETCH.
- Reset asserted mid-operation returns all outputs to the reset values at the next edge. No partial latch or display is completed.
- FSM states: FETCH (6 cycles per column), LATCH (1 cycle), DISPLAY (BRIGHTNESS_BASE<<plane cycles).
- FETCH, per column c (0..63, ascending), with r = row pair:
  - cycle 0: address {0,r,c,1}, read enable 1, clk=0.
  - cycle 1: address {0,r,c,0}; capture top high byte.
  - cycle 2: address {1,r,c,1}; capture top low byte.
  - cycle 3: address {1,r,c,0}; capture bottom high byte.
  - cycle 4: read enable 0; capture bottom low byte; drive rgb1/rgb2.
  - cycle 5: clk=1.
  - clk returns to 0 at the next column's cycle 0, or at LATCH.
  - FETCH takes 384 cycles per plane.
- Pixel decode for pixel P = {hi, lo} = R[4:0] G[5:0] B[4:0]:
  - r6 = {R, R[4]}, g6 = G, b6 = {B, B[4]}.
  - Output bit = channel6[plane] AND rgb_enable[channel], with rgb_enable sampled in FETCH cycle 4.
- oe_n stays 1 during FETCH and LATCH.
- LATCH: latch=1 and row_addr<=r for exactly this cycle; clk=0.
- DISPLAY:
  - brightness_enable[plane] is sampled on entry.
  - If the sampled bit is 1, oe_n=0 for exactly BRIGHTNESS_BASE<<plane cycles. If 0, oe_n stays 1 for the same duration, so timing is unchanged.
  - After DISPLAY: oe_n=1. If plane>0, plane decrements and the block returns to FETCH with column 0.
  - If plane==0, plane goes back to 5 and r increments, wrapping 15->0.
- frame_start pulses 1 for the first FETCH cycle of r=0, plane=5, including the first cycle after reset is released.
- Display of plane p for row pair r ends before the fetch of the next plane begins. Shift and display do not overlap.

Test Plan:
1. Hold reset for 3 cycles, then release -> every output at its reset value while reset is held; frame_start=1 on the first post-reset cycle together with ram_address=1 and ram_read_enable=1.
2. Observe the address sequence from reset release -> 1, 0, 2049, 2048 for col 0, then 3, 2, 2051, 2050 for col 1; hub75_clk shows 64 pulses, each 1 cycle high, at 6-cycle spacing.
3. Load top pixel (0,0)=0xF800 and bottom pixel (16,0)=0x001F, rgb_enable=3'b111 -> during plane 5, the first shifted column gives rgb1=3'b001 and rgb2=3'b100.
4. With BRIGHTNESS_BASE=8 and brightness_enable=6'b110111 -> oe_n low for 256 cycles on plane 5, high throughout plane 3's 64 cycles, low for 8 cycles on plane 0; latch pulses once per plane with row_addr=0.
5. rgb_enable=3'b110 with all pixels 0xFFFF -> rgb1[0] and rgb2[0] never 1, all other bits 1 in every plane. After 6 planes, row_addr=1 at the next latch; wrap 15->0 is accompanied by frame_start.
6. Assert reset at column 30 of FETCH -> next cycle clk=0, oe_n=1, rgb=0, and the sequence restarts from address 1 with frame_start.
